// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: FSM state encoding and the
// ASCII characters the parser recognises.
package uart_cmd_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_TERM    = 3'd5;
  localparam logic [2:0] ST_DISCARD = 3'd6;

  localparam logic [7:0] CH_W_UC = 8'h57;
  localparam logic [7:0] CH_W_LC = 8'h77;
  localparam logic [7:0] CH_R_UC = 8'h52;
  localparam logic [7:0] CH_R_LC = 8'h72;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  function automatic logic is_term_char(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/hex_char_decoder.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'a'-'f', 'A'-'F' -> nibble.
module hex_char_decoder (
  input  logic [7:0] ch_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    is_hex_o = 1'b0;
    nibble_o = 4'h0;
    if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
      is_hex_o = 1'b1;
      nibble_o = ch_i[3:0];
    end else if ((ch_i >= 8'h61 && ch_i <= 8'h66) || (ch_i >= 8'h41 && ch_i <= 8'h46)) begin
      // Letters a-f / A-F have low nibble 1..6, so add 9 to get 10..15.
      is_hex_o = 1'b1;
      nibble_o = ch_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "Waadd<term>" / "Raa<term>" ASCII hex commands from a UART byte stream
// and offers them on a valid/ready interface, with inter-byte timeout.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_write,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       cmd_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          wr_q, wr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          valid_q, valid_d, owrite_q, owrite_d, err_q, err_d;
  logic [7:0]    oaddr_q, oaddr_d, odata_q, odata_d;
  logic          is_hex, is_term;
  logic [3:0]    nibble;

  hex_char_decoder u_hex (
    .ch_i     (rx_data),
    .is_hex_o (is_hex),
    .nibble_o (nibble)
  );

  assign is_term = is_term_char(rx_data);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    owrite_d = owrite_q;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;
    err_d    = 1'b0;
    if (valid_q && cmd_ready) valid_d = 1'b0;

    if (new_rx_data) begin
      timer_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == CH_W_UC || rx_data == CH_W_LC) begin
            wr_d    = 1'b1;
            state_d = ST_ADDR_HI;
          end else if (rx_data == CH_R_UC || rx_data == CH_R_LC) begin
            wr_d    = 1'b0;
            state_d = ST_ADDR_HI;
          end else if (!is_term) begin
            state_d = ST_DISCARD;
          end
        end
        ST_ADDR_HI, ST_ADDR_LO: begin
          if (is_hex) begin
            addr_d = {addr_q[3:0], nibble};
            if (state_q == ST_ADDR_HI) state_d = ST_ADDR_LO;
            else if (wr_q)             state_d = ST_DATA_HI;
            else begin
              data_d  = 8'h00;
              state_d = ST_TERM;
            end
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_DATA_HI, ST_DATA_LO: begin
          if (is_hex) begin
            data_d  = {data_q[3:0], nibble};
            state_d = (state_q == ST_DATA_HI) ? ST_DATA_LO : ST_TERM;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_TERM: begin
          if (is_term) begin
            state_d = ST_IDLE;
            // A held, unaccepted command makes this one an overrun.
            if (!valid_q || cmd_ready) begin
              valid_d  = 1'b1;
              owrite_d = wr_q;
              oaddr_d  = addr_q;
              odata_d  = data_q;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (is_term) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      wr_q     <= 1'b0;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      owrite_q <= 1'b0;
      oaddr_q  <= 8'h00;
      odata_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      owrite_q <= owrite_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
      err_q    <= err_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_write = owrite_q;
  assign cmd_addr  = oaddr_q;
  assign cmd_data  = odata_q;
  assign cmd_err   = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected commands,
// a negedge monitor pops and compares on each accepted command.
module tb_uart_cmd_parser;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cmd_err;
  logic       busy;

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
  } cmd_t;

  cmd_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   err_seen = 0;
  int   err_exp  = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s ok value=%0h", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(posedge clk);
    #1;
    rx_data     = b;
    new_rx_data = 1'b1;
    @(posedge clk);
    #1;
    new_rx_data = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic accept();
    @(posedge clk);
    #1 cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    @(negedge clk);
    chk("valid_clears_after_accept", {31'd0, cmd_valid}, 32'd0);
  endtask

  task automatic chk_errs(input string name);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(name, err_seen, err_exp);
  endtask

  // Monitor: counts error pulses, checks hold stability and compares accepted commands.
  cmd_t held;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmd_err) err_seen++;
        if (cmd_valid && !prev_valid)
          chk("valid_rise_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (cmd_valid && prev_valid && !prev_ready)
          chk("held_stable", {15'd0, cmd_write, cmd_addr, cmd_data}, {15'd0, held});
        if (cmd_valid && cmd_ready) begin
          if (sb.size() == 0) begin
            chk("accept_with_empty_scoreboard", 32'd1, 32'd0);
          end else begin
            cmd_t e;
            e = sb.pop_front();
            chk("accept_write", {31'd0, cmd_write}, {31'd0, e.w});
            chk("accept_addr", {24'd0, cmd_addr}, {24'd0, e.a});
            chk("accept_data", {24'd0, cmd_data}, {24'd0, e.d});
          end
        end
        held = {cmd_write, cmd_addr, cmd_data};
      end
      prev_valid = cmd_valid;
      prev_ready = cmd_ready;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx_data = 8'h00;
    new_rx_data = 1'b0;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {19'd0, cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_err, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Write command, held until accepted.
    sb.push_back('{w: 1'b1, a: 8'h3A, d: 8'h5F});
    send_str("W3A5F");
    send_byte(8'h0D);
    @(negedge clk);
    chk("write_latency_valid", {31'd0, cmd_valid}, 32'd1);
    chk("write_fields", {15'd0, cmd_write, cmd_addr, cmd_data}, {15'd0, 1'b1, 8'h3A, 8'h5F});
    repeat (4) @(posedge clk);
    accept();

    // Read command, then a blank line.
    sb.push_back('{w: 1'b0, a: 8'h0C, d: 8'h00});
    send_str("r0c");
    send_byte(8'h0A);
    accept();
    send_byte(8'h0D);
    repeat (4) @(negedge clk);
    chk("blank_no_valid", {31'd0, cmd_valid}, 32'd0);
    chk_errs("blank_no_err");

    // Malformed command then a good read.
    send_str("W3G12");
    send_byte(8'h0D);
    err_exp++;
    chk_errs("malformed_err");
    chk("malformed_busy", {31'd0, busy}, 32'd0);
    chk("malformed_no_valid", {31'd0, cmd_valid}, 32'd0);
    sb.push_back('{w: 1'b0, a: 8'h01, d: 8'h00});
    send_str("R01");
    send_byte(8'h0D);
    accept();

    // Inter-byte timeout.
    send_str("W3");
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("timeout_busy_before", {31'd0, busy}, 32'd1);
    chk("timeout_no_early_err", err_seen, err_exp);
    repeat (60) @(posedge clk);
    err_exp++;
    chk_errs("timeout_err");
    chk("timeout_busy_after", {31'd0, busy}, 32'd0);
    sb.push_back('{w: 1'b1, a: 8'h01, d: 8'h02});
    send_str("W0102");
    send_byte(8'h0D);
    accept();

    // Overrun: second command dropped while first is held.
    sb.push_back('{w: 1'b1, a: 8'h11, d: 8'h22});
    send_str("W1122");
    send_byte(8'h0D);
    send_str("W3344");
    send_byte(8'h0D);
    err_exp++;
    chk_errs("overrun_err");
    chk("overrun_held", {15'd0, cmd_write, cmd_addr, cmd_data}, {15'd0, 1'b1, 8'h11, 8'h22});
    accept();
    repeat (5) @(negedge clk);
    chk("overrun_no_second_valid", {31'd0, cmd_valid}, 32'd0);

    // Async reset mid-command with a pending valid.
    sb.push_back('{w: 1'b0, a: 8'h55, d: 8'h00});
    send_str("R55");
    send_byte(8'h0D);
    send_str("W12");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {19'd0, cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_err, busy}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {19'd0, cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_err, busy}, 32'd0);
    sb.push_back('{w: 1'b0, a: 8'h7F, d: 8'h00});
    send_str("R7F");
    send_byte(8'h0D);
    @(negedge clk);
    chk("reset_read_fields", {15'd0, cmd_write, cmd_addr, cmd_data}, {15'd0, 1'b0, 8'h7F, 8'h00});
    accept();
    chk_errs("final_err_count");
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
